mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage data-access engine: decodes the one-hot mem_control bundle, runs one
// transaction at a time on the SRAM-like data bus and returns extended load data.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid,
  input  logic [7:0]        mem_control,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata_in,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata_out,
  output logic              addr_err,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_wr;
  logic                r_sext;
  logic [1:0]          r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;

  logic                w_any;
  logic                w_wr;
  logic                w_sext;
  logic [1:0]          w_size;
  logic                w_misaligned;
  logic                w_idle;
  logic                w_start;
  logic                w_capture;
  logic [31:0]         w_wdata_rep;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;

  // Highest set bit wins when the decoder hands us more than one op.
  always_comb begin
    w_size = 2'd0;
    w_wr   = 1'b0;
    w_sext = 1'b0;
    if (mem_control[7]) begin
      w_size = 2'd0;
      w_sext = 1'b1;
    end else if (mem_control[6]) begin
      w_size = 2'd0;
    end else if (mem_control[5]) begin
      w_size = 2'd1;
      w_sext = 1'b1;
    end else if (mem_control[4]) begin
      w_size = 2'd1;
    end else if (mem_control[3]) begin
      w_size = 2'd2;
    end else if (mem_control[2]) begin
      w_size = 2'd0;
      w_wr   = 1'b1;
    end else if (mem_control[1]) begin
      w_size = 2'd1;
      w_wr   = 1'b1;
    end else if (mem_control[0]) begin
      w_size = 2'd2;
      w_wr   = 1'b1;
    end
  end

  assign w_any        = |mem_control;
  assign w_misaligned = ((w_size == 2'd1) && addr[0]) ||
                        ((w_size == 2'd2) && (addr[1:0] != 2'b00));
  assign w_idle       = (r_state == StIdle);
  assign w_start      = w_idle && valid && w_any && !w_misaligned;
  assign addr_err     = w_idle && valid && w_any && w_misaligned;

  always_comb begin
    case (w_size)
      2'd0:    w_wdata_rep = {4{wdata_in[7:0]}};
      2'd1:    w_wdata_rep = {2{wdata_in[15:0]}};
      default: w_wdata_rep = wdata_in;
    endcase
  end

  assign w_capture = ((r_state == StReq) && data_addr_ok && data_data_ok) ||
                     ((r_state == StWait) && data_data_ok);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: if (w_start) w_state_nxt = StReq;
      StReq: begin
        if (data_addr_ok) w_state_nxt = data_data_ok ? StResp : StWait;
      end
      StWait: if (data_data_ok) w_state_nxt = StResp;
      StResp: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
      r_wr    <= 1'b0;
      r_sext  <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_wr    <= w_wr;
        r_sext  <= w_sext;
        r_size  <= w_size;
        r_addr  <= addr;
        r_wdata <= w_wdata_rep;
      end
      if (w_capture) r_rdata <= data_rdata;
    end
  end

  // Lane select and extension operate on the captured word, never on the live bus.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = r_rdata[7:0];
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      default: w_byte = r_rdata[31:24];
    endcase
    w_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_size)
      2'd0:    w_load = {{24{r_sext & w_byte[7]}}, w_byte};
      2'd1:    w_load = {{16{r_sext & w_half[15]}}, w_half};
      default: w_load = r_rdata;
    endcase
  end

  assign rdata_out  = ((r_state == StResp) && !r_wr) ? w_load : 32'h0;
  assign done       = (r_state == StResp);
  assign data_req   = (r_state == StReq);
  assign stall      = w_start || (r_state == StReq) || (r_state == StWait);
  assign data_wr    = r_wr;
  assign data_size  = r_size;
  assign data_addr  = r_addr;
  assign data_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid;
  logic [7:0]  mem_control;
  logic [31:0] addr;
  logic [31:0] wdata_in;
  logic        stall;
  logic        done;
  logic [31:0] rdata_out;
  logic        addr_err;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .valid        (valid),
    .mem_control  (mem_control),
    .addr         (addr),
    .wdata_in     (wdata_in),
    .stall        (stall),
    .done         (done),
    .rdata_out    (rdata_out),
    .addr_err     (addr_err),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  // Transaction-level model: busy from acceptance until the done cycle.
  bit        m_busy, m_aok, m_dok;
  int        m_op;
  bit [31:0] m_addr, m_wdata_bus, m_result;
  bit        e_stall, e_done, e_err, e_req, e_wr;
  bit [1:0]  e_size;
  bit [31:0] e_addr, e_wdata, e_rdata;
  bit        chk_en = 1'b0;

  // Op index: 7 lb, 6 lbu, 5 lh, 4 lhu, 3 lw, 2 sb, 1 sh, 0 sw.
  function automatic int top_op(input bit [7:0] mc);
    for (int i = 7; i >= 0; i--) if (mc[i]) return i;
    return -1;
  endfunction

  function automatic int op_size(input int op);
    case (op)
      7, 6, 2: return 0;
      5, 4, 1: return 1;
      default: return 2;
    endcase
  endfunction

  function automatic bit op_misaligned(input int op, input bit [31:0] a);
    int sz;
    sz = op_size(op);
    return (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
  endfunction

  function automatic bit [31:0] store_data(input int op, input bit [31:0] wd);
    case (op_size(op))
      0:       return (wd % 256) * 32'h0101_0101;
      1:       return (wd % 65536) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic bit [31:0] load_result(input int op, input bit [31:0] a,
                                             input bit [31:0] rd);
    bit [31:0] v;
    if (op <= 2) return 32'h0;
    if (op_size(op) == 0) begin
      v = (rd >> (8 * (a % 4))) % 256;
      if (op == 7 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (op_size(op) == 1) begin
      v = (rd >> (16 * ((a / 2) % 2))) % 65536;
      if (op == 5 && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Advance the model across the edge just taken, using the inputs sampled there.
  task automatic model_edge();
    int op;
    if (m_dok) begin
      m_busy = 0; m_aok = 0; m_dok = 0;
    end else if (m_busy && !m_aok) begin
      if (data_addr_ok) begin
        m_aok = 1;
        if (data_data_ok) begin
          m_dok = 1;
          m_result = load_result(m_op, m_addr, data_rdata);
        end
      end
    end else if (m_busy) begin
      if (data_data_ok) begin
        m_dok = 1;
        m_result = load_result(m_op, m_addr, data_rdata);
      end
    end else begin
      op = top_op(mem_control);
      if (valid && op >= 0 && !op_misaligned(op, addr)) begin
        m_busy = 1; m_aok = 0; m_dok = 0;
        m_op = op; m_addr = addr; m_wdata_bus = store_data(op, wdata_in);
      end
    end
  endtask

  task automatic model_expect();
    int op;
    e_stall = 0; e_done = 0; e_err = 0; e_req = 0; e_wr = 0;
    e_size = 2'd0; e_addr = 0; e_wdata = 0; e_rdata = 0;
    if (!m_busy) begin
      op = top_op(mem_control);
      if (valid && op >= 0) begin
        if (op_misaligned(op, addr)) e_err = 1;
        else e_stall = 1;
      end
    end else if (m_dok) begin
      e_done = 1;
      e_rdata = m_result;
    end else begin
      e_stall = 1;
      e_req = !m_aok;
      e_wr = (m_op <= 2);
      e_size = 2'(op_size(m_op));
      e_addr = m_addr;
      e_wdata = m_wdata_bus;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(e_stall));
      check("done", 32'(done), 32'(e_done));
      check("addr_err", 32'(addr_err), 32'(e_err));
      check("data_req", 32'(data_req), 32'(e_req));
      if (e_req) begin
        check("data_wr", 32'(data_wr), 32'(e_wr));
        check("data_size", 32'(data_size), 32'(e_size));
        check("data_addr", data_addr, e_addr);
        check("data_wdata", data_wdata, e_wdata);
      end
      if (e_done) check("rdata_out", rdata_out, e_rdata);
    end
  end

  task automatic drive(input bit v, input bit [7:0] mc, input bit [31:0] a,
                       input bit [31:0] wd, input bit aok, input bit dok,
                       input bit [31:0] rd);
    valid = v; mem_control = mc; addr = a; wdata_in = wd;
    data_addr_ok = aok; data_data_ok = dok; data_rdata = rd;
    model_expect();
  endtask

  task automatic step(input bit v, input bit [7:0] mc, input bit [31:0] a,
                      input bit [31:0] wd, input bit aok, input bit dok,
                      input bit [31:0] rd);
    @(posedge clk); #1;
    model_edge();
    drive(v, mc, a, wd, aok, dok, rd);
    @(negedge clk); #1;
  endtask

  task automatic rand_step();
    bit        v, aok, dok;
    bit [7:0]  mc;
    bit [31:0] a;
    int        sel;
    @(posedge clk); #1;
    model_edge();
    v = ($urandom_range(0, 3) != 0);
    sel = $urandom_range(0, 9);
    if (sel == 0) mc = 8'h00;
    else if (sel <= 6) mc = 8'h01 << $urandom_range(0, 7);
    else mc = 8'($urandom);
    a = $urandom;
    if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
    if (m_busy && !m_aok && !m_dok) begin
      aok = ($urandom_range(0, 1) == 1);
      dok = aok ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
    end else if (m_busy && !m_dok) begin
      aok = ($urandom_range(0, 7) == 0);
      dok = ($urandom_range(0, 2) == 0);
    end else begin
      aok = 0;
      dok = ($urandom_range(0, 7) == 0);
    end
    drive(v, mc, a, $urandom, aok, dok, $urandom);
    @(negedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"}, 32'(stall), 32'h0);
    check({tag, ".done"}, 32'(done), 32'h0);
    check({tag, ".addr_err"}, 32'(addr_err), 32'h0);
    check({tag, ".data_req"}, 32'(data_req), 32'h0);
    check({tag, ".data_wr"}, 32'(data_wr), 32'h0);
    check({tag, ".data_size"}, 32'(data_size), 32'h0);
    check({tag, ".data_addr"}, data_addr, 32'h0);
    check({tag, ".data_wdata"}, data_wdata, 32'h0);
    check({tag, ".rdata_out"}, rdata_out, 32'h0);
  endtask

  bit [31:0] lb_exp [4];

  initial begin
    lb_exp[0] = 32'h0000_0001;
    lb_exp[1] = 32'h0000_007F;
    lb_exp[2] = 32'hFFFF_FFFF;
    lb_exp[3] = 32'hFFFF_FF80;
    resetn = 1'b0;
    valid = 0; mem_control = 0; addr = 0; wdata_in = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    #12;
    check_all_zero("reset");
    #10 resetn = 1'b1;
    chk_en = 1'b1;

    // lw, split handshake
    step(1, 8'h08, 32'h1000, 0, 0, 0, 0);
    check("lw.T.stall", 32'(stall), 32'h1);
    check("lw.T.req", 32'(data_req), 32'h0);
    step(1, 8'h08, 32'h1000, 0, 1, 0, 0);
    check("lw.T1.req", 32'(data_req), 32'h1);
    check("lw.T1.addr", data_addr, 32'h1000);
    check("lw.T1.size", 32'(data_size), 32'h2);
    step(1, 8'h08, 32'h1000, 0, 0, 0, 0);
    check("lw.T2.req", 32'(data_req), 32'h0);
    check("lw.T2.stall", 32'(stall), 32'h1);
    step(1, 8'h08, 32'h1000, 0, 0, 1, 32'hDEAD_BEEF);
    check("lw.T3.stall", 32'(stall), 32'h1);
    check("lw.T3.done", 32'(done), 32'h0);
    step(0, 8'h00, 0, 0, 0, 0, 0);
    check("lw.T4.done", 32'(done), 32'h1);
    check("lw.T4.stall", 32'(stall), 32'h0);
    check("lw.T4.rdata", rdata_out, 32'hDEAD_BEEF);

    // lb per lane, lbu lane 3
    for (int lane = 0; lane < 4; lane++) begin
      step(1, 8'h80, 32'h3000 + 32'(lane), 0, 0, 0, 0);
      step(1, 8'h80, 32'h3000 + 32'(lane), 0, 1, 1, 32'h80FF_7F01);
      step(0, 8'h00, 0, 0, 0, 0, 0);
      check("lb.lane", rdata_out, lb_exp[lane]);
    end
    step(1, 8'h40, 32'h3003, 0, 0, 0, 0);
    step(1, 8'h40, 32'h3003, 0, 1, 1, 32'h80FF_7F01);
    step(0, 8'h00, 0, 0, 0, 0, 0);
    check("lbu.lane3", rdata_out, 32'h0000_0080);

    // sh at 0x2002
    step(1, 8'h02, 32'h2002, 32'h1234_ABCD, 0, 0, 0);
    step(1, 8'h02, 32'h2002, 32'h1234_ABCD, 1, 1, 32'h5555_5555);
    check("sh.wr", 32'(data_wr), 32'h1);
    check("sh.size", 32'(data_size), 32'h1);
    check("sh.wdata", data_wdata, 32'hABCD_ABCD);
    check("sh.addr", data_addr, 32'h2002);
    step(0, 8'h00, 0, 0, 0, 0, 0);
    check("sh.done", 32'(done), 32'h1);
    check("sh.rdata", rdata_out, 32'h0);

    // misaligned lw and sh
    step(1, 8'h08, 32'h1001, 0, 0, 0, 0);
    check("mis.lw.err", 32'(addr_err), 32'h1);
    check("mis.lw.stall", 32'(stall), 32'h0);
    step(1, 8'h02, 32'h1001, 0, 0, 0, 0);
    check("mis.sh.err", 32'(addr_err), 32'h1);
    check("mis.sh.stall", 32'(stall), 32'h0);
    check("mis.sh.req", 32'(data_req), 32'h0);
    step(0, 8'h00, 0, 0, 0, 0, 0);
    check("mis.req", 32'(data_req), 32'h0);

    // same-cycle handshake, then back-to-back sb
    step(1, 8'h08, 32'h4000, 0, 0, 0, 0);
    step(1, 8'h08, 32'h4000, 0, 1, 1, 32'h0000_55AA);
    step(1, 8'h04, 32'h4005, 32'h77, 0, 0, 0);
    check("b2b.T2.done", 32'(done), 32'h1);
    check("b2b.T2.stall", 32'(stall), 32'h0);
    check("b2b.T2.rdata", rdata_out, 32'h0000_55AA);
    step(1, 8'h04, 32'h4005, 32'h77, 0, 0, 0);
    check("b2b.T3.stall", 32'(stall), 32'h1);
    check("b2b.T3.req", 32'(data_req), 32'h0);
    step(1, 8'h04, 32'h4005, 32'h77, 0, 0, 0);
    check("b2b.T4.req", 32'(data_req), 32'h1);
    check("b2b.T4.wdata", data_wdata, 32'h7777_7777);
    step(0, 8'h00, 0, 0, 1, 1, 0);
    step(0, 8'h00, 0, 0, 0, 0, 0);
    check("b2b.sb.done", 32'(done), 32'h1);

    // reset while in WAIT
    step(1, 8'h08, 32'h5000, 0, 0, 0, 0);
    step(1, 8'h08, 32'h5000, 0, 1, 0, 0);
    step(1, 8'h08, 32'h5000, 0, 0, 0, 0);
    check("rst.wait.stall", 32'(stall), 32'h1);
    chk_en = 1'b0;
    valid = 0; mem_control = 0; addr = 0;
    resetn = 1'b0;
    #1;
    check_all_zero("midrst");
    m_busy = 0; m_aok = 0; m_dok = 0;
    #2 resetn = 1'b1;
    chk_en = 1'b1;
    step(0, 8'h00, 0, 0, 0, 1, 32'h1234_5678);
    step(0, 8'h00, 0, 0, 0, 0, 0);
    check("rst.nodone", 32'(done), 32'h0);

    for (int i = 0; i < 3000; i++) rand_step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
